// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port synchronous RAM.
// Define RAM_ARB_RR_EN for round-robin arbitration; fixed priority (port 0) otherwise.
module ram_arbiter #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_wea,
    input  logic [DW-1:0] ram_dout,
    output logic          busy,
    output logic          owner
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t        state_q, state_d;
    logic          op_we_q, op_we_d;
    logic [AW-1:0] ram_addr_d;
    logic [DW-1:0] ram_din_d;
    logic          ram_wea_d;
    logic          owner_d;
    logic          busy_d;
    logic          ack0_d, ack1_d;
    logic [DW-1:0] rdata0_d, rdata1_d;

    logic          grant;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

`ifdef RAM_ARB_RR_EN
    logic last_q, last_d;

    // On a tie the port not granted last time wins
    always_comb begin
        if (req0 && req1) begin
            grant = ~last_q;
        end else begin
            grant = req1;
        end
    end
`else
    always_comb begin
        grant = ~req0;
    end
`endif

    always_comb begin
        win_we    = grant ? we1    : we0;
        win_addr  = grant ? addr1  : addr0;
        win_wdata = grant ? wdata1 : wdata0;
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        op_we_d    = op_we_q;
        ram_addr_d = ram_addr;
        ram_din_d  = ram_din;
        ram_wea_d  = 1'b0;
        owner_d    = owner;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        rdata0_d   = rdata0;
        rdata1_d   = rdata1;
`ifdef RAM_ARB_RR_EN
        last_d     = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d    = ISSUE;
                    ram_addr_d = win_addr;
                    ram_din_d  = win_wdata;
                    ram_wea_d  = win_we;
                    op_we_d    = win_we;
                    owner_d    = grant;
`ifdef RAM_ARB_RR_EN
                    last_d     = grant;
`endif
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                // ram_dout now reflects the address sampled at the end of ISSUE
                if (!op_we_q) begin
                    if (owner) begin
                        rdata1_d = ram_dout;
                    end else begin
                        rdata0_d = ram_dout;
                    end
                end
                if (owner) begin
                    ack1_d = 1'b1;
                end else begin
                    ack0_d = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_we_q  <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            ram_wea  <= 1'b0;
            owner    <= 1'b0;
            busy     <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
`ifdef RAM_ARB_RR_EN
            last_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            op_we_q  <= op_we_d;
            ram_addr <= ram_addr_d;
            ram_din  <= ram_din_d;
            ram_wea  <= ram_wea_d;
            owner    <= owner_d;
            busy     <= busy_d;
            ack0     <= ack0_d;
            ack1     <= ack1_d;
            rdata0   <= rdata0_d;
            rdata1   <= rdata1_d;
`ifdef RAM_ARB_RR_EN
            last_q   <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural RAM and an ack scoreboard.
// Expectations follow RAM_ARB_RR_EN when it is defined for the build.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [7:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1;
    logic [15:0] rdata0, rdata1;
    logic [7:0]  ram_addr;
    logic [15:0] ram_din;
    logic        ram_wea;
    logic [15:0] ram_dout;
    logic        busy, owner;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          port;
        bit          we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    typedef struct {
        bit          port;
        logic [15:0] rdata;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];

    always #5 clk = ~clk;

    ram_arbiter #(.AW(8), .DW(16)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_wea(ram_wea), .ram_dout(ram_dout),
        .busy(busy), .owner(owner)
    );

    // Single-port RAM, registered read; unwritten words read as 16'h5A00 | addr
    logic [15:0] mem [256];
    bit          written [256];
    always @(posedge clk) begin
        ram_dout <= written[ram_addr] ? mem[ram_addr] : {8'h5A, ram_addr};
        if (ram_wea) begin
            mem[ram_addr]     <= ram_din;
            written[ram_addr] <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input bit p, input logic [15:0] r);
        exp_t e;
        e.port  = p;
        e.rdata = r;
        sb.push_back(e);
    endtask

    // Wait for the falling edge and score any acknowledge seen there
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (ack0 || ack1) begin
            check("ack_exclusive", 32'(ack0 & ack1), 32'd0);
            if (sb.size() == 0) begin
                check("spurious_ack", 32'(ack1), 32'(ack0));
                checks--;
                failures++;
                $display("FAIL spurious_ack: got ack0=%0b ack1=%0b expected none", ack0, ack1);
            end else begin
                e = sb.pop_front();
                check("ack_port", 32'(ack1), 32'(e.port));
                check("rdata", 32'(e.port ? rdata1 : rdata0), 32'(e.rdata));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input bit p, input bit r, input bit w, input logic [7:0] a,
                            input logic [15:0] d);
        if (p) begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    // One access on one port; checks strobe, address, owner and ack latency
    task automatic single(input string tag, input bit p, input bit w, input logic [7:0] a,
                          input logic [15:0] d, input logic [15:0] exp_r);
        int  ack_at  = -1;
        int  wea_cnt = 0;
        bit  seen;
        step();
        set_port(p, 1'b1, w, a, d);
        push_exp(p, exp_r);
        for (int k = 0; k < 12 && ack_at < 0; k++) begin
            tick();
            if (k == 1) begin
                check({tag, " owner"}, 32'(owner), 32'(p));
                check({tag, " busy"}, 32'(busy), 32'd1);
                check({tag, " ram_addr"}, 32'(ram_addr), 32'(a));
                if (w) check({tag, " ram_din"}, 32'(ram_din), 32'(d));
            end
            if (ram_wea) wea_cnt++;
            seen = p ? ack1 : ack0;
            if (seen) ack_at = k;
            step();
            if (seen) set_port(p, 1'b0, w, a, d);
        end
        set_port(p, 1'b0, w, a, d);
        check({tag, " ack_latency"}, 32'(ack_at), 32'd3);
        check({tag, " wea_pulses"}, 32'(wea_cnt), 32'(w));
        tick();
        check({tag, " ack_cleared"}, 32'(ack0 | ack1), 32'd0);
        check({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int  t0, t1, n0, n1;
        bit  a0, a1;

        vecs[0]  = '{1'b0, 1'b1, 8'h10, 16'hA5A5, 16'h0000};
        vecs[1]  = '{1'b1, 1'b0, 8'h10, 16'h0000, 16'hA5A5};
        vecs[2]  = '{1'b0, 1'b0, 8'h10, 16'h0000, 16'hA5A5};
        vecs[3]  = '{1'b1, 1'b1, 8'hFF, 16'hBEEF, 16'hA5A5};
        vecs[4]  = '{1'b0, 1'b0, 8'hFF, 16'h0000, 16'hBEEF};
        vecs[5]  = '{1'b1, 1'b0, 8'h00, 16'h0000, 16'h5A00};
        vecs[6]  = '{1'b0, 1'b1, 8'h00, 16'h1234, 16'hBEEF};
        vecs[7]  = '{1'b1, 1'b0, 8'h00, 16'h0000, 16'h1234};
        vecs[8]  = '{1'b0, 1'b0, 8'h22, 16'h0000, 16'h5A22};
        vecs[9]  = '{1'b1, 1'b1, 8'h22, 16'hFFFF, 16'h1234};
        vecs[10] = '{1'b1, 1'b0, 8'h22, 16'h0000, 16'hFFFF};
        vecs[11] = '{1'b0, 1'b0, 8'h01, 16'h0000, 16'h5A01};

        rst = 1'b1;
        set_port(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        set_port(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);

        // Reset values
        tick();
        check("rst ack0", 32'(ack0), 32'd0);
        check("rst ack1", 32'(ack1), 32'd0);
        check("rst ram_wea", 32'(ram_wea), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst owner", 32'(owner), 32'd0);
        check("rst ram_addr", 32'(ram_addr), 32'd0);
        check("rst ram_din", 32'(ram_din), 32'd0);
        check("rst rdata0", 32'(rdata0), 32'd0);
        check("rst rdata1", 32'(rdata1), 32'd0);
        step();
        rst = 1'b0;

        foreach (vecs[i]) begin
            single($sformatf("vec%0d", i), vecs[i].port, vecs[i].we, vecs[i].addr,
                   vecs[i].wdata, vecs[i].exp_rdata);
        end

        // Simultaneous writes; last grant so far went to port 0
        step();
        set_port(1'b0, 1'b1, 1'b1, 8'h01, 16'h1111);
        set_port(1'b1, 1'b1, 1'b1, 8'h02, 16'h2222);
`ifdef RAM_ARB_RR_EN
        push_exp(1'b1, 16'hFFFF);
        push_exp(1'b0, 16'h5A01);
`else
        push_exp(1'b0, 16'h5A01);
        push_exp(1'b1, 16'hFFFF);
`endif
        t0 = -1;
        t1 = -1;
        for (int k = 0; k < 16 && (t0 < 0 || t1 < 0); k++) begin
            tick();
            a0 = ack0;
            a1 = ack1;
            if (a0) t0 = k;
            if (a1) t1 = k;
            step();
            if (a0) req0 = 1'b0;
            if (a1) req1 = 1'b0;
        end
        req0 = 1'b0;
        req1 = 1'b0;
`ifdef RAM_ARB_RR_EN
        check("tie ack1 time", 32'(t1), 32'd3);
        check("tie ack0 time", 32'(t0), 32'd7);
`else
        check("tie ack0 time", 32'(t0), 32'd3);
        check("tie ack1 time", 32'(t1), 32'd7);
`endif
        single("readback01", 1'b0, 1'b0, 8'h01, 16'h0000, 16'h1111);
        single("readback02", 1'b1, 1'b0, 8'h02, 16'h0000, 16'h2222);

        // Continuous contention for 40 cycles
        step();
        set_port(1'b0, 1'b1, 1'b0, 8'h01, 16'h0000);
        set_port(1'b1, 1'b1, 1'b0, 8'h02, 16'h0000);
        for (int g = 0; g < 10; g++) begin
`ifdef RAM_ARB_RR_EN
            if (g % 2 == 0) push_exp(1'b0, 16'h1111);
            else            push_exp(1'b1, 16'h2222);
`else
            push_exp(1'b0, 16'h1111);
`endif
        end
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (ack0) n0++;
            if (ack1) n1++;
            step();
        end
        req0 = 1'b0;
        req1 = 1'b0;
`ifdef RAM_ARB_RR_EN
        check("contend ack0 count", 32'(n0), 32'd5);
        check("contend ack1 count", 32'(n1), 32'd5);
`else
        check("contend ack0 count", 32'(n0), 32'd10);
        check("contend ack1 count", 32'(n1), 32'd0);
`endif
        check("contend sb drained", 32'(sb.size()), 32'd0);
        tick();
        check("contend idle", 32'(busy), 32'd0);

        // Reset during CAPTURE of a port-0 read
        step();
        set_port(1'b0, 1'b1, 1'b0, 8'h10, 16'h0000);
        tick();
        step();
        tick();
        step();
        rst  = 1'b1;
        req0 = 1'b0;
        tick();
        step();
        rst = 1'b0;
        tick();
        check("midrst ack0", 32'(ack0), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst owner", 32'(owner), 32'd0);
        check("midrst ram_wea", 32'(ram_wea), 32'd0);
        check("midrst ram_addr", 32'(ram_addr), 32'd0);
        check("midrst ram_din", 32'(ram_din), 32'd0);
        check("midrst rdata0", 32'(rdata0), 32'd0);
        check("midrst rdata1", 32'(rdata1), 32'd0);
        n0 = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            tick();
            if (ack0 || ack1) n0++;
        end
        check("midrst no late ack", 32'(n0), 32'd0);

        single("post_rst_ff", 1'b1, 1'b0, 8'hFF, 16'h0000, 16'hBEEF);
        single("post_rst_10", 1'b0, 1'b0, 8'h10, 16'h0000, 16'hA5A5);

        check("sb empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
